// File: rtl/shim_ad5676_dac_spi_ctrl.sv
// AD5676 SPI command shifter with programmable n_cs high time.
// Define SHIM_AD5676_READBACK_EN to build the sdo readback capture path.
module shim_ad5676_dac_spi_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  n_cs_high_time,
  input  logic        timing_done,
  input  logic [23:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        n_cs,
  output logic        sclk_en,
  output logic        sdi,
  input  logic        sdo,
  output logic [23:0] rx_data,
  output logic        rx_valid,
  output logic        busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_CS_HIGH = 2'd2;

  logic [1:0]  state_r;
  logic [23:0] shift_r;
  logic [4:0]  bit_cnt_r;
  logic [4:0]  high_time_r;
  logic [4:0]  high_cnt_r;
  logic        accept_s;

  assign cmd_ready = resetn && (state_r == S_IDLE) && timing_done;
  assign busy      = (state_r != S_IDLE);
  assign accept_s  = cmd_valid && cmd_ready;

  // Transaction FSM; sdi is preloaded with the MSB so bit 23 is on the wire in the first n_cs-low cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      shift_r     <= 24'd0;
      bit_cnt_r   <= 5'd0;
      high_time_r <= 5'd0;
      high_cnt_r  <= 5'd0;
      n_cs        <= 1'b1;
      sclk_en     <= 1'b0;
      sdi         <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            state_r     <= S_SHIFT;
            shift_r     <= {cmd_data[22:0], 1'b0};
            high_time_r <= n_cs_high_time;
            bit_cnt_r   <= 5'd23;
            n_cs        <= 1'b0;
            sclk_en     <= 1'b1;
            sdi         <= cmd_data[23];
          end else begin
            n_cs    <= 1'b1;
            sclk_en <= 1'b0;
            sdi     <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (bit_cnt_r == 5'd0) begin
            state_r    <= S_CS_HIGH;
            high_cnt_r <= high_time_r;
            n_cs       <= 1'b1;
            sclk_en    <= 1'b0;
            sdi        <= 1'b0;
          end else begin
            sdi       <= shift_r[23];
            shift_r   <= {shift_r[22:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - 5'd1;
          end
        end
        S_CS_HIGH: begin
          if (high_cnt_r == 5'd0) begin
            state_r <= S_IDLE;
          end else begin
            high_cnt_r <= high_cnt_r - 5'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          n_cs    <= 1'b1;
          sclk_en <= 1'b0;
          sdi     <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHIM_AD5676_READBACK_EN
  // Only 23 bits are held: the 24th sample goes straight into rx_data.
  logic [22:0] rx_sr_r;

  // Readback capture, published on the S_SHIFT -> S_CS_HIGH transition.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_sr_r  <= 23'd0;
      rx_data  <= 24'd0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state_r == S_SHIFT) begin
        rx_sr_r <= {rx_sr_r[21:0], sdo};
        if (bit_cnt_r == 5'd0) begin
          rx_data  <= {rx_sr_r, sdo};
          rx_valid <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_sdo;
  assign unused_sdo = sdo;
  assign rx_data    = 24'd0;
  assign rx_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_shim_ad5676_dac_spi_ctrl.sv
// Directed, table-driven bench for shim_ad5676_dac_spi_ctrl (either build of SHIM_AD5676_READBACK_EN).
module tb_shim_ad5676_dac_spi_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  n_cs_high_time;
  logic        timing_done;
  logic [23:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        n_cs;
  logic        sclk_en;
  logic        sdi;
  logic        sdo;
  logic [23:0] rx_data;
  logic        rx_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SHIM_AD5676_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  shim_ad5676_dac_spi_ctrl dut (
    .clk(clk), .resetn(resetn), .n_cs_high_time(n_cs_high_time), .timing_done(timing_done),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .n_cs(n_cs),
    .sclk_en(sclk_en), .sdi(sdi), .sdo(sdo), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] cmd;
    logic [4:0]  nht;
    logic [23:0] pat;
    int          exp_hi;
    int          exp_period;
    logic [23:0] exp_word;
    logic [23:0] exp_rx;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at the negedge of the first n_cs-low cycle; returns at the first idle negedge.
  task automatic monitor(input logic [23:0] pat, output int lo, output int hi, output int rxc,
                         output int rxf, output int bad, output logic [23:0] w);
    lo = 0; hi = 0; rxc = 0; rxf = 0; bad = 0; w = 24'd0;
    for (int c = 0; c < 100; c++) begin
      if (rx_valid) begin
        rxc++;
        if (n_cs && busy && hi == 0) rxf = 1;
      end
      if (!n_cs) begin
        w = {w[22:0], sdi};
        if (!sclk_en || !busy || cmd_ready) bad++;
        sdo = (lo < 24) ? pat[23 - lo] : 1'b0;
        lo++;
      end else if (busy) begin
        if (sclk_en || sdi || cmd_ready) bad++;
        hi++;
      end else begin
        break;
      end
      @(negedge clk);
    end
    sdo = 1'b0;
  endtask

  task automatic wait_idle_ready();
    int k;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_vec(input int i);
    int lo, hi, rxc, rxf, bad;
    logic [23:0] w;
    wait_idle_ready();
    cmd_data       = vecs[i].cmd;
    n_cs_high_time = vecs[i].nht;
    cmd_valid      = 1'b1;
    @(negedge clk);
    cmd_valid      = 1'b0;
    cmd_data       = ~vecs[i].cmd;
    n_cs_high_time = ~vecs[i].nht;
    monitor(vecs[i].pat, lo, hi, rxc, rxf, bad, w);
    chk($sformatf("v%0d_low_cycles", i), lo, 24);
    chk($sformatf("v%0d_high_cycles", i), hi, vecs[i].exp_hi);
    chk($sformatf("v%0d_period", i), 1 + lo + hi, vecs[i].exp_period);
    chk($sformatf("v%0d_sdi_word", i), {8'd0, w}, {8'd0, vecs[i].exp_word});
    chk($sformatf("v%0d_pin_rules", i), bad, 0);
    chk($sformatf("v%0d_rx_pulses", i), rxc, RB);
    chk($sformatf("v%0d_rx_at_first_high", i), rxf, RB);
    chk($sformatf("v%0d_rx_data", i), {8'd0, rx_data}, {8'd0, vecs[i].exp_rx});
    chk($sformatf("v%0d_ready_after", i), {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int lo, hi, rxc, rxf, bad, f1, f2, stall_bad;
    logic [23:0] w;
    logic prev;

    vecs[0] = '{24'h3A5F0F, 5'd3,  24'hC0FFEE, 4,  29, 24'h3A5F0F, 24'd0};
    vecs[1] = '{24'h800001, 5'd0,  24'h5A5A5A, 1,  26, 24'h800001, 24'd0};
    vecs[2] = '{24'hFFFFFF, 5'd31, 24'h000000, 32, 57, 24'hFFFFFF, 24'd0};
    vecs[3] = '{24'h000000, 5'd10, 24'hFFFFFF, 11, 36, 24'h000000, 24'd0};
    vecs[4] = '{24'h123456, 5'd7,  24'h654321, 8,  33, 24'h123456, 24'd0};
`ifdef SHIM_AD5676_READBACK_EN
    vecs[0].exp_rx = 24'hC0FFEE;
    vecs[1].exp_rx = 24'h5A5A5A;
    vecs[2].exp_rx = 24'h000000;
    vecs[3].exp_rx = 24'hFFFFFF;
    vecs[4].exp_rx = 24'h654321;
`endif

    resetn = 1'b0; timing_done = 1'b1; cmd_valid = 1'b1; cmd_data = 24'hABCDEF;
    n_cs_high_time = 5'd3; sdo = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_n_cs", {31'd0, n_cs}, 32'd1);
    chk("rst_sclk_en", {31'd0, sclk_en}, 32'd0);
    chk("rst_sdi", {31'd0, sdi}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rx_data", {8'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    cmd_valid = 1'b0; sdo = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i);

    // timing_done low holds off a pending command; acceptance follows in the cycle it rises
    timing_done = 1'b0; cmd_valid = 1'b1; cmd_data = 24'h3A5F0F; n_cs_high_time = 5'd2;
    stall_bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cmd_ready || !n_cs || busy) stall_bad++;
    end
    chk("td_low_stall", stall_bad, 0);
    timing_done = 1'b1;
    #1;
    chk("td_rise_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("td_rise_n_cs_low", {31'd0, n_cs}, 32'd0);
    monitor(24'd0, lo, hi, rxc, rxf, bad, w);
    chk("td_high_cycles", hi, 3);

    // Back-to-back words with cmd_valid held and the maximum high time
    wait_idle_ready();
    cmd_data = 24'h111111; n_cs_high_time = 5'd31; cmd_valid = 1'b1;
    prev = n_cs; f1 = -1; f2 = -1;
    for (int t = 1; t < 150; t++) begin
      @(negedge clk);
      if (prev && !n_cs) begin
        if (f1 < 0) f1 = t;
        else if (f2 < 0) f2 = t;
      end
      prev = n_cs;
      if (f2 >= 0) break;
    end
    cmd_valid = 1'b0;
    chk("b2b_first_fall", f1, 1);
    chk("b2b_spacing", f2 - f1, 57);
    wait_idle_ready();

    // High time latched at accept; timing_done loss mid-word neither truncates nor restarts
    cmd_data = 24'h0F0F0F; n_cs_high_time = 5'd3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_cs_high_time = 5'd10; timing_done = 1'b0;
    monitor(24'd0, lo, hi, rxc, rxf, bad, w);
    chk("mid_low_remaining", lo, 15);
    chk("mid_high_cycles", hi, 4);
    cmd_valid = 1'b1;
    stall_bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (cmd_ready || !n_cs || busy || sclk_en) stall_bad++;
      @(negedge clk);
    end
    chk("mid_idle_stall", stall_bad, 0);
    cmd_valid = 1'b0; timing_done = 1'b1;
    #1;
    chk("mid_resume_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    // Reset in the middle of S_SHIFT aborts on the next edge
    cmd_data = 24'hFFFFFF; n_cs_high_time = 5'd5; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("abort_pre_n_cs", {31'd0, n_cs}, 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_n_cs", {31'd0, n_cs}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sclk_en", {31'd0, sclk_en}, 32'd0);
    chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_no_rx_valid", {31'd0, rx_valid}, 32'd0);
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
